// File: rtl/rotate_stepper.sv
// -----------------------------------------------------------------------------
// rotate_stepper
//
// Closed-loop sequencer around an external 8-bit left rotator. A start request
// loads a byte, a rotate amount and a step count. The current value is then
// presented to the rotator, and every TICK_DIV clocks the rotated result is
// captured back. A run lasts a finite number of steps (1..15), or continues
// until stop when the step count is 0. The current value also drives the
// board LEDs.
//
// Parameters
//   TICK_DIV     clocks per rotation step (>= 1; 1 = step every clock)
//   CNT_W        tick counter width, 2**CNT_W >= TICK_DIV
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   start        one-cycle run request (ignored while busy)
//   stop         abort request, has priority over start
//   load_data    initial byte, sampled when start is accepted
//   load_amount  rotate-left amount per step, sampled with start
//   load_steps   step count, 0 = continuous until stop
//   rot_in       to rotator data input (current value)
//   rot_amt      to rotator amount input (latched amount)
//   rot_out      from rotator, combinational rotated value
//   d_out        current value (LED drive)
//   busy         high while running or signalling done
//   step_pulse   high in the cycle whose closing edge captures rot_out
//   done         one-cycle pulse after the last step of a finite run
// -----------------------------------------------------------------------------
module rotate_stepper #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] load_data,
    input  logic [2:0] load_amount,
    input  logic [3:0] load_steps,
    output logic [7:0] rot_in,
    output logic [2:0] rot_amt,
    input  logic [7:0] rot_out,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       step_pulse,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last count value of a step period; the counter resets here rather than
    // free-running, so a step period is exactly TICK_DIV clocks.
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [7:0]       cur_q, cur_d;
    logic [2:0]       amt_q, amt_d;
    logic [3:0]       steps_left_q, steps_left_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;

    // The rotator is combinational and sits outside this block; feed it
    // straight from the registers so a capture sees this cycle's result.
    assign rot_in  = cur_q;
    assign rot_amt = amt_q;
    assign d_out   = cur_q;
    assign busy    = (state_q != S_IDLE);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        amt_d        = amt_q;
        steps_left_d = steps_left_q;
        tick_cnt_d   = tick_cnt_q;
        step_pulse   = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    cur_d        = load_data;
                    amt_d        = load_amount;
                    steps_left_d = load_steps;
                    tick_cnt_d   = '0;
                    state_d      = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // Abort wins over a coinciding step: no capture, no done.
                    tick_cnt_d = '0;
                    state_d    = S_IDLE;
                end else if (tick_cnt_q == TICK_LAST) begin
                    step_pulse = 1'b1;
                    cur_d      = rot_out;
                    tick_cnt_d = '0;
                    // steps_left == 0 marks a continuous run; it never counts.
                    if (steps_left_q != 4'd0) begin
                        steps_left_d = steps_left_q - 4'd1;
                        if (steps_left_q == 4'd1) begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            amt_q        <= '0;
            steps_left_q <= '0;
            tick_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            amt_q        <= amt_d;
            steps_left_q <= steps_left_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

endmodule

// File: tb/tb_rotate_stepper.sv
// -----------------------------------------------------------------------------
// tb_rotate_stepper
//
// Drives rotate_stepper (TICK_DIV=4) in a loop with a behavioural 8-bit left
// rotator. Expected capture values are queued when a run is started and
// popped as each step lands.
// -----------------------------------------------------------------------------
module tb_rotate_stepper;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;
    localparam int BUDGET   = 4 * TICK_DIV + 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] load_data;
    logic [2:0] load_amount;
    logic [3:0] load_steps;
    logic [7:0] rot_in;
    logic [2:0] rot_amt;
    logic [7:0] rot_out;
    logic [7:0] d_out;
    logic       busy;
    logic       step_pulse;
    logic       done;

    logic [15:0] rot_wide;

    int total;
    int bad;
    logic [7:0] exp_q[$];

    rotate_stepper #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .load_data   (load_data),
        .load_amount (load_amount),
        .load_steps  (load_steps),
        .rot_in      (rot_in),
        .rot_amt     (rot_amt),
        .rot_out     (rot_out),
        .d_out       (d_out),
        .busy        (busy),
        .step_pulse  (step_pulse),
        .done        (done)
    );

    // Behavioural rotator: the upper byte of the doubled word shifted left.
    assign rot_wide = {rot_in, rot_in} << rot_amt;
    assign rot_out  = rot_wide[15:8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rotate, one bit at a time.
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < a; i++) begin
            r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    task automatic push_expected(input logic [7:0] v, input int a, input int n);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < n; i++) begin
            x = rotl8(x, a);
            exp_q.push_back(x);
        end
    endtask

    // Called at a negedge; leaves start low at the following negedge.
    task automatic do_start(input logic [7:0] data, input logic [2:0] amt, input logic [3:0] steps);
        load_data   = data;
        load_amount = amt;
        load_steps  = steps;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Waits for a step pulse, then one more cycle, and reports what the
    // outputs look like after the capture edge.
    task automatic wait_step(output bit got, output int cycles, output logic [7:0] val,
                             output logic done_s, output logic busy_s);
        got    = 1'b0;
        cycles = 0;
        val    = 8'h00;
        done_s = 1'b0;
        busy_s = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            cycles++;
            if (step_pulse === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            @(negedge clk);
            cycles++;
            val    = d_out;
            done_s = done;
            busy_s = busy;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({d_out, busy, step_pulse, done} !== 11'h000) begin
            bad++;
            $display("FAIL reset_outputs: got d_out=%h busy=%b step=%b done=%b want 00 0 0 0",
                     d_out, busy, step_pulse, done);
        end
        total++;
        if ({rot_in, rot_amt} !== 11'h000) begin
            bad++;
            $display("FAIL reset_rot: got rot_in=%h rot_amt=%0d want 00 0", rot_in, rot_amt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_finite;
        bit got; int cyc; logic [7:0] val; logic dn; logic bz; logic [7:0] e;
        exp_q.delete();
        push_expected(8'h81, 1, 3);
        do_start(8'h81, 3'd1, 4'd3);
        total++;
        if ({busy, rot_in, rot_amt} !== {1'b1, 8'h81, 3'd1}) begin
            bad++;
            $display("FAIL finite_load: got busy=%b rot_in=%h rot_amt=%0d want 1 81 1",
                     busy, rot_in, rot_amt);
        end
        for (int s = 0; s < 3; s++) begin
            wait_step(got, cyc, val, dn, bz);
            total++;
            if (!got || exp_q.size() == 0) begin
                bad++;
                $display("FAIL finite_step%0d_timeout: got no step want step", s);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (val !== e) begin
                    bad++;
                    $display("FAIL finite_step%0d_value: got %h want %h", s, val, e);
                end
                total++;
                if (cyc != TICK_DIV) begin
                    bad++;
                    $display("FAIL finite_step%0d_spacing: got %0d want %0d", s, cyc, TICK_DIV);
                end
                total++;
                if ({dn, bz} !== {(s == 2), 1'b1}) begin
                    bad++;
                    $display("FAIL finite_step%0d_done_busy: got done=%b busy=%b want %b 1",
                             s, dn, bz, (s == 2));
                end
            end
        end
        @(negedge clk);
        total++;
        if ({busy, done, d_out} !== {1'b0, 1'b0, 8'h0C}) begin
            bad++;
            $display("FAIL finite_end: got busy=%b done=%b d_out=%h want 0 0 0c", busy, done, d_out);
        end
    endtask

    task automatic test_start_ignored;
        bit got; int cyc; logic [7:0] val; logic dn; logic bz; logic [7:0] e;
        exp_q.delete();
        push_expected(8'h81, 1, 3);
        do_start(8'h81, 3'd1, 4'd3);
        for (int s = 0; s < 3; s++) begin
            wait_step(got, cyc, val, dn, bz);
            total++;
            if (!got || exp_q.size() == 0) begin
                bad++;
                $display("FAIL ignore_step%0d_timeout: got no step want step", s);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (val !== e) begin
                    bad++;
                    $display("FAIL ignore_step%0d_value: got %h want %h", s, val, e);
                end
                if (s == 1) begin
                    // One cycle of this period was spent on the stray start.
                    total++;
                    if (cyc != TICK_DIV - 1) begin
                        bad++;
                        $display("FAIL ignore_step1_spacing: got %0d want %0d", cyc, TICK_DIV - 1);
                    end
                end
            end
            if (s == 0) begin
                do_start(8'hFF, 3'd5, 4'd1);
                total++;
                if (rot_amt !== 3'd1) begin
                    bad++;
                    $display("FAIL ignore_amt: got %0d want 1", rot_amt);
                end
            end
        end
        @(negedge clk);
        total++;
        if ({busy, d_out} !== {1'b0, 8'h0C}) begin
            bad++;
            $display("FAIL ignore_end: got busy=%b d_out=%h want 0 0c", busy, d_out);
        end
    endtask

    task automatic test_continuous_stop;
        bit got; int cyc; logic [7:0] val; logic dn; logic bz; logic [7:0] e;
        int spurious;
        exp_q.delete();
        push_expected(8'h01, 3, 3);
        do_start(8'h01, 3'd3, 4'd0);
        for (int s = 0; s < 3; s++) begin
            wait_step(got, cyc, val, dn, bz);
            total++;
            if (!got || exp_q.size() == 0) begin
                bad++;
                $display("FAIL cont_step%0d_timeout: got no step want step", s);
            end else begin
                e = exp_q.pop_front();
                total++;
                if ({val, dn, bz} !== {e, 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL cont_step%0d: got d_out=%h done=%b busy=%b want %h 0 1",
                             s, val, dn, bz, e);
                end
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if ({busy, done, d_out} !== {1'b0, 1'b0, 8'h02}) begin
            bad++;
            $display("FAIL cont_stop: got busy=%b done=%b d_out=%h want 0 0 02", busy, done, d_out);
        end
        spurious = 0;
        repeat (2 * TICK_DIV) begin
            @(negedge clk);
            if (done !== 1'b0 || step_pulse !== 1'b0 || d_out !== 8'h02) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL cont_after_stop: got %0d bad cycles want 0", spurious);
        end
    endtask

    task automatic test_reset_midrun;
        bit got; int cyc; logic [7:0] val; logic dn; logic bz;
        int spurious;
        exp_q.delete();
        push_expected(8'h01, 3, 1);
        do_start(8'h01, 3'd3, 4'd0);
        wait_step(got, cyc, val, dn, bz);
        total++;
        if (!got || exp_q.size() == 0 || val !== exp_q[0]) begin
            bad++;
            $display("FAIL rstmid_first_step: got step=%b d_out=%h want 1 08", got, val);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({d_out, busy, step_pulse, rot_amt} !== {8'h00, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL rstmid_outputs: got d_out=%h busy=%b step=%b rot_amt=%0d want 00 0 0 0",
                     d_out, busy, step_pulse, rot_amt);
        end
        rst_n = 1'b1;
        spurious = 0;
        repeat (2 * TICK_DIV) begin
            @(negedge clk);
            if (done !== 1'b0 || step_pulse !== 1'b0 || busy !== 1'b0) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL rstmid_after: got %0d bad cycles want 0", spurious);
        end
    endtask

    task automatic test_amt_zero;
        bit got; int cyc; logic [7:0] val; logic dn; logic bz; logic [7:0] e;
        int done_cnt;
        exp_q.delete();
        push_expected(8'hA5, 0, 2);
        do_start(8'hA5, 3'd0, 4'd2);
        done_cnt = 0;
        for (int s = 0; s < 2; s++) begin
            wait_step(got, cyc, val, dn, bz);
            total++;
            if (!got || exp_q.size() == 0) begin
                bad++;
                $display("FAIL amt0_step%0d_timeout: got no step want step", s);
            end else begin
                e = exp_q.pop_front();
                if (dn === 1'b1) done_cnt++;
                total++;
                if (val !== e) begin
                    bad++;
                    $display("FAIL amt0_step%0d_value: got %h want %h", s, val, e);
                end
            end
        end
        repeat (TICK_DIV + 2) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL amt0_done: got done_pulses=%0d busy=%b want 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_start_stop;
        int spurious;
        load_data   = 8'h3C;
        load_amount = 3'd2;
        load_steps  = 4'd1;
        start       = 1'b1;
        stop        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        total++;
        if ({busy, d_out} !== {1'b0, 8'hA5}) begin
            bad++;
            $display("FAIL startstop_idle: got busy=%b d_out=%h want 0 a5", busy, d_out);
        end
        spurious = 0;
        repeat (TICK_DIV + 2) begin
            @(negedge clk);
            if (step_pulse !== 1'b0 || busy !== 1'b0 || d_out !== 8'hA5) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL startstop_after: got %0d bad cycles want 0", spurious);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        load_data   = 8'h00;
        load_amount = 3'd0;
        load_steps  = 4'd0;
        @(negedge clk);

        test_reset();
        test_finite();
        test_start_ignored();
        test_continuous_stop();
        test_reset_midrun();
        test_amt_zero();
        test_start_stop();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
